// File: rtl/apb_sched_pkg.sv
// Shared types and helpers for the APB round-robin scheduler.
package apb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, searched cyclically.
module apb_rr_pick
  import apb_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  assign any = |req;

  // Walk offsets from the far end back to zero so the nearest hit overwrites the rest.
  always_comb begin
    int cand;
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    cand  = 0;
    idx   = '0;
    grant = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand]) idx = IW'(cand);
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/apb_rr_scheduler.sv
// Round-robin sharing of one APB master port among NREQ single-beat requesters.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_rr_scheduler
  import apb_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*DATAWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  input  logic                      PCLKEN,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic [ADDRWIDTH-1:0]      PADDR,
  output logic                      PWRITE,
  output logic [DATAWIDTH-1:0]      PWDATA,
  input  logic [DATAWIDTH-1:0]      PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int IW = clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("apb_rr_scheduler: NREQ must be 2..8 and TIMEOUT at least 2");
  end

  state_t                state, state_nxt;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         win_idx;
  logic [NREQ-1:0]       win_onehot;
  logic                  any_req;
  logic                  grant_en;
  logic                  xfer_done;
  logic                  xfer_abort;
  logic [ADDRWIDTH-1:0]  sel_addr;
  logic [DATAWIDTH-1:0]  sel_wdata;

  apb_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (any_req)
  );

  assign grant_en  = (state == IDLE) && PCLKEN && any_req;
  assign req_ready = grant_en ? win_onehot : '0;
  assign xfer_done = (state == ACCESS) && PCLKEN && PREADY;
  assign sel_addr  = req_addr[int'(win_idx) * ADDRWIDTH +: ADDRWIDTH];
  assign sel_wdata = req_wdata[int'(win_idx) * DATAWIDTH +: DATAWIDTH];

`ifdef APB_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT);
  logic [TW-1:0] to_cnt;

  // The abort fires on the PCLKEN cycle that would have pushed the count past TIMEOUT-1.
  assign xfer_abort = (state == ACCESS) && PCLKEN && !PREADY && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      to_cnt <= '0;
    end else if (grant_en) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && PCLKEN && !PREADY && !xfer_abort) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign xfer_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (grant_en) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL = 1'b1;
        if (PCLKEN) state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (xfer_done || xfer_abort) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[gnt_idx] = 1'b1;
        state_nxt          = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command registers drive the APB bus directly, so they only move on a grant.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr     <= '0;
      gnt_idx <= '0;
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
    end else if (grant_en) begin
      ptr     <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      gnt_idx <= win_idx;
      PADDR   <= {sel_addr[ADDRWIDTH-1:2], 2'b00};
      PWRITE  <= req_write[win_idx];
      PWDATA  <= sel_wdata;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (xfer_done) begin
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_err   <= PSLVERR;
    end else if (xfer_abort) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (state == RESP) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Scoreboard bench for apb_rr_scheduler; covers the APB_TIMEOUT_EN build as well as the default one.
module tb_apb_rr_scheduler;
  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 32;

  logic                 HCLK = 1'b0;
  logic                 HRESET;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 PCLKEN;
  logic                 PSEL;
  logic                 PENABLE;
  logic [AW-1:0]        PADDR;
  logic                 PWRITE;
  logic [DW-1:0]        PWDATA;
  logic [DW-1:0]        PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  always #5 HCLK = ~HCLK;

  apb_rr_scheduler #(.NREQ(NREQ), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(16)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PCLKEN    (PCLKEN),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  typedef struct {
    int           idx;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } cmd_t;

  exp_t sb[$];
  cmd_t pend0[$];
  cmd_t pend1[$];

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0, grant_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, issue_cyc = 0;
  int psel_cnt = 0, pen_cnt = 0, acc_cnt = 0, stall = 0, pclken_mode = 0, rsp_before = 0;
  bit stuck = 1'b0, paddr_moved = 1'b0, prev_acc = 1'b0;
  logic [AW-1:0]   prev_paddr;
  logic [NREQ-1:0] grant_seen;
  logic [DW-1:0]   s_rdata;
  logic            s_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int i, input cmd_t c);
    req_addr[i*AW +: AW]  = c.addr;
    req_write[i]          = c.wr;
    req_wdata[i*DW +: DW] = c.wdata;
    req_valid[i]          = 1'b1;
  endtask

  task automatic load_next(input int i);
    cmd_t c;
    if (i == 0 && pend0.size() != 0) begin
      c = pend0.pop_front();
      drive(0, c);
    end else if (i == 1 && pend1.size() != 0) begin
      c = pend1.pop_front();
      drive(1, c);
    end
  endtask

  task automatic issue(input int i, input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata);
    cmd_t c;
    c.addr  = addr;
    c.wr    = wr;
    c.wdata = wdata;
    if (i == 0) pend0.push_back(c);
    else        pend1.push_back(c);
    if (!req_valid[i]) load_next(i);
  endtask

  task automatic expect_rsp(input int i, input logic [AW-1:0] addr, input logic wr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.idx = i; e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // One HCLK: observe at the falling edge, then update requesters and the APB slave just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge HCLK);
    grant_seen = req_valid & req_ready;
    if (grant_seen != '0) begin
      grant_cyc = cyc;
      if (sb.size() == 0) check("unexpected_grant", grant_seen, 0);
      else                check("grant_order", grant_seen, NREQ'(1) << sb[0].idx);
    end
    if (PSEL)    psel_cnt++;
    if (PENABLE) pen_cnt++;
    if (PSEL && PENABLE) begin
      if (prev_acc && PADDR !== prev_paddr) paddr_moved = 1'b1;
      prev_paddr = PADDR;
    end
    prev_acc = PSEL && PENABLE;
    if (PSEL && PENABLE && PCLKEN && PREADY && sb.size() != 0) begin
      check("paddr", PADDR, {sb[0].addr[AW-1:2], 2'b00});
      check("pwrite", PWRITE, sb[0].wr);
      if (sb[0].wr) check("pwdata", PWDATA, sb[0].wdata);
    end
    if (PSEL && PENABLE && PCLKEN && !PREADY) acc_cnt++;
    if (rsp_valid != '0) begin
      rsp_cyc = cyc;
      rsp_cnt++;
      if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 0);
      else begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, NREQ'(1) << e.idx);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
      end
    end
    @(posedge HCLK);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_seen[i]) begin
        req_valid[i] = 1'b0;
        load_next(i);
      end
    end
    if (!(PSEL && PENABLE)) acc_cnt = 0;
    PREADY  = PSEL && PENABLE && !stuck && (acc_cnt >= stall);
    PRDATA  = s_rdata;
    PSLVERR = s_err;
    PCLKEN  = (pclken_mode == 0) ? 1'b1 : (cyc % 2 == 0);
  endtask

  task automatic wait_rsp(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (rsp_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (rsp_cnt < target) check(tag, rsp_cnt, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1; req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    PCLKEN = 1'b1; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    s_rdata = '0; s_err = 1'b0; prev_paddr = '0; grant_seen = '0;
    repeat (2) tick();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);
    HRESET = 1'b0;

    // Single read from requester 0 on an unaligned address.
    s_rdata = 32'hA5A5_0001; stall = 0; s_err = 1'b0; psel_cnt = 0;
    expect_rsp(0, 16'h0013, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0);
    issue(0, 16'h0013, 1'b0, 32'h0);
    wait_rsp("t1_no_rsp", 1, 20);
    check("t1_latency", rsp_cyc - grant_cyc, 3);
    check("t1_psel_cycles", psel_cnt, 2);
    check("t1_clear_rdata", rsp_rdata, 0);
    check("t1_clear_valid", rsp_valid, 0);

    // Read from requester 1 alone; moves the pointer back to 0.
    s_rdata = 32'h0BAD_F00D;
    expect_rsp(1, 16'h0102, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);
    issue(1, 16'h0102, 1'b0, 32'h0);
    wait_rsp("t1b_no_rsp", 2, 20);

    // Both requesters held valid for two writes each: grants alternate 0,1,0,1.
    expect_rsp(0, 16'h0200, 1'b1, 32'h1111_0000, 32'h0, 1'b0);
    expect_rsp(1, 16'h0304, 1'b1, 32'h2222_0001, 32'h0, 1'b0);
    expect_rsp(0, 16'h0208, 1'b1, 32'h1111_0002, 32'h0, 1'b0);
    expect_rsp(1, 16'h030C, 1'b1, 32'h2222_0003, 32'h0, 1'b0);
    issue(0, 16'h0200, 1'b1, 32'h1111_0000);
    issue(0, 16'h0208, 1'b1, 32'h1111_0002);
    issue(1, 16'h0304, 1'b1, 32'h2222_0001);
    issue(1, 16'h030C, 1'b1, 32'h2222_0003);
    wait_rsp("t2_no_rsp", 6, 40);

    // Slave stalls three ACCESS cycles, then flags an error on a write.
    stall = 3; s_err = 1'b1; pen_cnt = 0; paddr_moved = 1'b0;
    expect_rsp(0, 16'h1237, 1'b1, 32'hCAFE_0004, 32'h0, 1'b1);
    issue(0, 16'h1237, 1'b1, 32'hCAFE_0004);
    wait_rsp("t3_no_rsp", 7, 30);
    check("t3_penable_cycles", pen_cnt, 4);
    check("t3_paddr_stable", paddr_moved, 0);
    stall = 0; s_err = 1'b0;

    // PCLKEN alternating: request raised on a disabled cycle.
    pclken_mode = 1;
    for (int n = 0; n < 3 && PCLKEN; n++) tick();
    s_rdata = 32'h5A5A_0005; psel_cnt = 0; pen_cnt = 0; issue_cyc = cyc;
    expect_rsp(1, 16'h0440, 1'b0, 32'h0, 32'h5A5A_0005, 1'b0);
    issue(1, 16'h0440, 1'b0, 32'h0);
    wait_rsp("t4_no_rsp", 8, 30);
    check("t4_grant_delay", grant_cyc - issue_cyc, 1);
    check("t4_rsp_delay", rsp_cyc - issue_cyc, 6);
    check("t4_psel_cycles", psel_cnt, 4);
    check("t4_penable_cycles", pen_cnt, 2);
    pclken_mode = 0;
    tick();

    // Slave never ready.
    stuck = 1'b1; s_rdata = 32'hDEAD_BEEF;
`ifdef APB_TIMEOUT_EN
    expect_rsp(0, 16'h0500, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(0, 16'h0500, 1'b0, 32'h0);
    wait_rsp("t5_no_abort", 9, 40);
    check("t5_abort_latency", rsp_cyc - grant_cyc, 18);
    expect_rsp(0, 16'h0504, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(0, 16'h0504, 1'b0, 32'h0);
    repeat (4) tick();
`else
    rsp_before = rsp_cnt;
    expect_rsp(0, 16'h0500, 1'b0, 32'h0, 32'h0, 1'b1);
    issue(0, 16'h0500, 1'b0, 32'h0);
    repeat (100) tick();
    check("t5_no_rsp_while_stuck", rsp_cnt, rsp_before);
`endif

    // Reset in the middle of ACCESS.
    check("t6_in_access", {PSEL, PENABLE}, 2'b11);
    HRESET = 1'b1;
    #1;
    check("t6_psel_drop", PSEL, 0);
    check("t6_penable_drop", PENABLE, 0);
    rsp_before = rsp_cnt;
    req_valid = '0; pend0.delete(); pend1.delete(); sb.delete(); stuck = 1'b0;
    repeat (3) tick();
    HRESET = 1'b0;
    tick();
    check("t6_no_rsp_after_reset", rsp_cnt, rsp_before);
    expect_rsp(0, 16'h0600, 1'b1, 32'h7777_0006, 32'h0, 1'b0);
    expect_rsp(1, 16'h0700, 1'b1, 32'h8888_0007, 32'h0, 1'b0);
    issue(1, 16'h0700, 1'b1, 32'h8888_0007);
    issue(0, 16'h0600, 1'b1, 32'h7777_0006);
    wait_rsp("t6_no_rsp", rsp_before + 2, 30);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
